wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the five-stage pipeline. It consumes the MEM/WB pipeline register outputs, selects the write-back value (ALU result, load data or link address), commits it to a 2^ASIZE-entry register file, and serves the two combinational read ports used by the ID stage. It also exports the committed write for EX-stage forwarding and keeps a count of committed writes.

## Interface
- DSIZE, 32: data and register width
- ASIZE, 5: register address width (32 registers)
- ISIZE, 32: PC width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- alu_in  in  DSIZE  ALU result from MEM/WB
- mem_rdata_in  in  DSIZE  data-memory read data, valid in the WB cycle
- pc_in  in  ISIZE  return address for jal (already PC+1 word / PC+4 byte, computed upstream)
- waddr_in  in  ASIZE  destination register
- jal_in, memtoReg_in, wen_in  in  1 each  write-back controls from MEM/WB
- raddr1, raddr2  in  ASIZE  ID-stage read addresses
- rdata1, rdata2  out  DSIZE  combinational read data
- wb_wen  out  1  effective write enable this cycle
- wb_waddr  out  ASIZE  write address this cycle
- wb_data  out  DSIZE  selected write-back value this cycle
- wb_count  out  32  number of committed register writes

## Operation
- Write-back select, priority order: jal_in -> pc_in (zero-extended or truncated to DSIZE); else memtoReg_in -> mem_rdata_in; else alu_in.
- Effective enable: wb_wen = wen_in & ~rst & (waddr_in != 0).
- wb_waddr = waddr_in, wb_data = selected value; both combinational, always driven, even when wb_wen=0.
- On posedge clk with wb_wen=1: reg[waddr_in] <= wb_data; wb_count <= wb_count + 1, wrapping from 0xFFFFFFFF to 0.
- Register 0: never written, always reads 0; writes to it do not increment wb_count.
- Reads: rdataN = 0 if raddrN==0, else reg[raddrN] (subject to bypass, see Configuration).
- Both read ports are independent; raddr1==raddr2 returns identical data.
- Reset (rst=1 at posedge): all registers and wb_count cleared to 0; any write presented in that cycle is discarded. Reset asserted mid-stream takes precedence over wen_in.

## Timing
- Write latency: one cycle; value is visible at rdataN (without bypass) from the cycle after the commit edge.
- Read latency: zero (combinational from raddrN and register state).
- wb_* outputs are combinational from the MEM/WB inputs; no added pipeline stage.
- Reset values: all registers 0, wb_count 0; rdata1/rdata2 read 0 after reset; wb_wen 0 while rst=1.
- No handshake; the block never stalls. Hazard stalling is the responsibility of the hazard unit.

## Configuration
- WB_BYPASS_EN defined: write-to-read bypass. If wb_wen=1 and raddrN==waddr_in, rdataN returns wb_data in the same cycle, so ID reads the value being written. Register 0 is never bypassed.
- WB_BYPASS_EN undefined: rdataN always returns stored state; a same-cycle read of the register being written returns the old value, and the hazard unit must stall one extra cycle.

## Test plan
- Reset, then read all 32 addresses on both ports -> every rdata = 0, wb_count = 0.
- wen_in=1, waddr_in=5, alu_in=0x1234_5678, memtoReg=0, jal=0; next cycle raddr1=5 -> rdata1=0x1234_5678, wb_count=1.
- Same cycle: wen_in=1, waddr_in=31, jal_in=1, memtoReg_in=1, pc_in=0x40, alu_in=0xFF, mem_rdata_in=0xAA -> reg31=0x40 (jal wins); then memtoReg_in=1, waddr_in=8, mem_rdata_in=0xAA -> reg8=0xAA.
- wen_in=1, waddr_in=0, alu_in=0xDEAD -> rdata of r0 stays 0, wb_count unchanged, wb_wen=0.
- Write r7=0x11 with raddr2=7 in the same cycle -> with WB_BYPASS_EN rdata2=0x11 that cycle; without it rdata2=old value (0), then 0x11 next cycle.
- Write r3=0x55, then assert rst together with wen_in=1, waddr_in=4, alu_in=0x66 -> after the edge r3=0, r4=0, wb_count=0; separately preload wb_count=0xFFFFFFFF by forcing, commit one write -> wb_count=0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB write-back and ID read-port signal bundle.
//   slave  modport: seen by wb_regfile (MEM/WB controls and read addresses in;
//                   read data and committed-write outputs out)
//   master modport: seen by the pipeline/driver side (the opposite directions)
// Signals:
//   alu_in, mem_rdata_in, pc_in    candidate write-back values
//   waddr_in, jal_in, memtoReg_in, wen_in   write-back controls
//   raddr1/raddr2 -> rdata1/rdata2  combinational ID read ports
//   wb_wen, wb_waddr, wb_data       committed write this cycle (for forwarding)
//   wb_count                        number of committed register writes
interface wb_regfile_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int ISIZE = 32
);
  logic [DSIZE-1:0] alu_in;
  logic [DSIZE-1:0] mem_rdata_in;
  logic [ISIZE-1:0] pc_in;
  logic [ASIZE-1:0] waddr_in;
  logic             jal_in;
  logic             memtoReg_in;
  logic             wen_in;
  logic [ASIZE-1:0] raddr1;
  logic [ASIZE-1:0] raddr2;
  logic [DSIZE-1:0] rdata1;
  logic [DSIZE-1:0] rdata2;
  logic             wb_wen;
  logic [ASIZE-1:0] wb_waddr;
  logic [DSIZE-1:0] wb_data;
  logic [31:0]      wb_count;

  modport slave (
    input  alu_in, mem_rdata_in, pc_in, waddr_in, jal_in, memtoReg_in, wen_in,
    input  raddr1, raddr2,
    output rdata1, rdata2, wb_wen, wb_waddr, wb_data, wb_count
  );

  modport master (
    output alu_in, mem_rdata_in, pc_in, waddr_in, jal_in, memtoReg_in, wen_in,
    output raddr1, raddr2,
    input  rdata1, rdata2, wb_wen, wb_waddr, wb_data, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage plus 2^ASIZE-entry architectural register file.
//   Selects the write-back value (jal link > load data > ALU result), commits
//   it on the rising clock edge, serves two combinational read ports and
//   counts committed writes (32-bit, wrapping).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (clears registers and write count,
//        discards the write presented in the same cycle)
//   bus  wb_regfile_if.slave (MEM/WB inputs, read ports, wb_* outputs)
// Build option:
//   WB_BYPASS_EN  when defined, a read of the register being written this
//                 cycle returns the value being written (r0 never bypassed).
//                 Undefined: reads always return stored state.

// One combinational read port; bypass is active only while byp_vld is high.
module wb_regfile_rport #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic [ASIZE-1:0]                 raddr,
  input  logic [2**ASIZE-1:0][DSIZE-1:0]   regs,
  input  logic                             byp_vld,
  input  logic [ASIZE-1:0]                 byp_addr,
  input  logic [DSIZE-1:0]                 byp_data,
  output logic [DSIZE-1:0]                 rdata
);
  always_comb begin
    rdata = '0;
    if (raddr != '0) begin
      if (byp_vld && (raddr == byp_addr)) rdata = byp_data;
      else                                rdata = regs[raddr];
    end
  end
endmodule

module wb_regfile #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int ISIZE = 32
) (
  input  logic        clk,
  input  logic        rst,
  wb_regfile_if.slave bus
);
  localparam int NREG  = 2**ASIZE;
  localparam int NPORT = 2;

  logic [NREG-1:0][DSIZE-1:0] regs_q;
  logic [31:0]                cnt_q;
  logic [DSIZE-1:0]           pc_ext;
  logic [DSIZE-1:0]           wdata;
  logic                       wen_eff;
  logic                       byp_vld;

  // Link address is resized to the data width (zero-extend or truncate).
  if (ISIZE >= DSIZE) begin : g_pc_trunc
    assign pc_ext = bus.pc_in[DSIZE-1:0];
  end else begin : g_pc_zext
    assign pc_ext = {{(DSIZE-ISIZE){1'b0}}, bus.pc_in};
  end

  always_comb begin
    wdata = bus.alu_in;
    if (bus.jal_in)           wdata = pc_ext;
    else if (bus.memtoReg_in) wdata = bus.mem_rdata_in;
  end

  // r0 writes and writes during reset are dropped here, so they neither
  // reach the array nor count.
  assign wen_eff = bus.wen_in & ~rst & (bus.waddr_in != '0);

  assign bus.wb_wen   = wen_eff;
  assign bus.wb_waddr = bus.waddr_in;
  assign bus.wb_data  = wdata;
  assign bus.wb_count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
      cnt_q  <= '0;
    end else if (wen_eff) begin
      regs_q[bus.waddr_in] <= wdata;
      cnt_q                <= cnt_q + 32'd1;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_vld = wen_eff;
`else
  assign byp_vld = 1'b0;
`endif

  logic [NPORT-1:0][ASIZE-1:0] raddr_v;
  logic [NPORT-1:0][DSIZE-1:0] rdata_v;

  assign raddr_v    = {bus.raddr2, bus.raddr1};
  assign bus.rdata1 = rdata_v[0];
  assign bus.rdata2 = rdata_v[1];

  for (genvar p = 0; p < NPORT; p++) begin : g_rport
    wb_regfile_rport #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_rport (
      .raddr    (raddr_v[p]),
      .regs     (regs_q),
      .byp_vld  (byp_vld),
      .byp_addr (bus.waddr_in),
      .byp_data (wdata),
      .rdata    (rdata_v[p])
    );
  end
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [31:0] mregs [32];
  logic [31:0] mcnt;

  wb_regfile_if #(.DSIZE(32), .ASIZE(5), .ISIZE(32)) bus ();

  wb_regfile #(.DSIZE(32), .ASIZE(5), .ISIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: value chosen by the priority rule.
  function automatic logic [31:0] sel_val();
    if (bus.jal_in)      return bus.pc_in;
    if (bus.memtoReg_in) return bus.mem_rdata_in;
    return bus.alu_in;
  endfunction

  function automatic logic exp_wen();
    return bus.wen_in && !rst && (bus.waddr_in != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (exp_wen() && bus.waddr_in == a) return sel_val();
`endif
    return mregs[a];
  endfunction

  // Advance one clock, applying the write rules to the model at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcnt = 32'd0;
    end else if (bus.wen_in && bus.waddr_in != 5'd0) begin
      mregs[bus.waddr_in] = sel_val();
      mcnt = mcnt + 32'd1;
    end
    #1;
  endtask

  task automatic drive(input logic wen, input logic [4:0] wa, input logic jal,
                       input logic m2r, input logic [31:0] alu,
                       input logic [31:0] mrd, input logic [31:0] pc);
    bus.wen_in = wen; bus.waddr_in = wa; bus.jal_in = jal;
    bus.memtoReg_in = m2r; bus.alu_in = alu; bus.mem_rdata_in = mrd;
    bus.pc_in = pc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 5'd9, 1'b0, 1'b0, 32'h77, 32'h0, 32'h0);
    n_chk++;
    if (bus.wb_wen !== 1'b0) begin
      n_fail++; $display("FAIL reset_wen: got %b want 0", bus.wb_wen);
    end
    tick(); tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    n_chk++;
    if (bus.wb_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_count: got %h want 0", bus.wb_count);
    end
    for (int a = 0; a < 32; a++) begin
      bus.raddr1 = a[4:0]; bus.raddr2 = 5'(31 - a);
      #1;
      n_chk++;
      if (bus.rdata1 !== 32'd0 || bus.rdata2 !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_read a=%0d: got %h/%h want 0/0", a, bus.rdata1, bus.rdata2);
      end
    end
  endtask

  task automatic test_alu_write();
    drive(1'b1, 5'd5, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 32'h0);
    n_chk++;
    if (bus.wb_wen !== 1'b1 || bus.wb_waddr !== 5'd5 || bus.wb_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL alu_wb_out: got %b/%h/%h want 1/05/12345678", bus.wb_wen, bus.wb_waddr, bus.wb_data);
    end
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.raddr1 = 5'd5; #1;
    n_chk++;
    if (bus.rdata1 !== 32'h1234_5678 || bus.wb_count !== 32'd1) begin
      n_fail++;
      $display("FAIL alu_write: got %h cnt %0d want 12345678 cnt 1", bus.rdata1, bus.wb_count);
    end
  endtask

  task automatic test_select();
    drive(1'b1, 5'd31, 1'b1, 1'b1, 32'hFF, 32'hAA, 32'h40);
    n_chk++;
    if (bus.wb_data !== 32'h40) begin
      n_fail++; $display("FAIL sel_jal_comb: got %h want 40", bus.wb_data);
    end
    tick();
    drive(1'b1, 5'd8, 1'b0, 1'b1, 32'hFF, 32'hAA, 32'h40);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.raddr1 = 5'd31; bus.raddr2 = 5'd8; #1;
    n_chk++;
    if (bus.rdata1 !== 32'h40) begin
      n_fail++; $display("FAIL sel_jal: got %h want 40", bus.rdata1);
    end
    n_chk++;
    if (bus.rdata2 !== 32'hAA) begin
      n_fail++; $display("FAIL sel_mem: got %h want aa", bus.rdata2);
    end
  endtask

  task automatic test_r0();
    logic [31:0] cnt0;
    cnt0 = bus.wb_count;
    drive(1'b1, 5'd0, 1'b0, 1'b0, 32'hDEAD, 32'h0, 32'h0);
    bus.raddr1 = 5'd0; bus.raddr2 = 5'd0; #1;
    n_chk++;
    if (bus.wb_wen !== 1'b0 || bus.rdata1 !== 32'd0 || bus.rdata2 !== 32'd0) begin
      n_fail++; $display("FAIL r0_same: got wen %b rd %h want 0/0", bus.wb_wen, bus.rdata1);
    end
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    n_chk++;
    if (bus.rdata1 !== 32'd0 || bus.wb_count !== cnt0 || bus.wb_count !== mcnt) begin
      n_fail++;
      $display("FAIL r0_write: got rd %h cnt %0d want 0 cnt %0d", bus.rdata1, bus.wb_count, mcnt);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
`ifdef WB_BYPASS_EN
    want = 32'h11;
`else
    want = 32'h0;
`endif
    drive(1'b1, 5'd7, 1'b0, 1'b0, 32'h11, 32'h0, 32'h0);
    bus.raddr2 = 5'd7; bus.raddr1 = 5'd7; #1;
    n_chk++;
    if (bus.rdata2 !== want || bus.rdata1 !== want) begin
      n_fail++; $display("FAIL bypass_same: got %h/%h want %h", bus.rdata1, bus.rdata2, want);
    end
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    n_chk++;
    if (bus.rdata2 !== 32'h11) begin
      n_fail++; $display("FAIL bypass_next: got %h want 11", bus.rdata2);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd3, 1'b0, 1'b0, 32'h55, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    drive(1'b1, 5'd4, 1'b0, 1'b0, 32'h66, 32'h0, 32'h0);
    n_chk++;
    if (bus.wb_wen !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_wen: got %b want 0", bus.wb_wen);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.raddr1 = 5'd3; bus.raddr2 = 5'd4; #1;
    n_chk++;
    if (bus.rdata1 !== 32'd0 || bus.rdata2 !== 32'd0 || bus.wb_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid: got r3 %h r4 %h cnt %0d want 0 0 0", bus.rdata1, bus.rdata2, bus.wb_count);
    end
  endtask

  task automatic test_wrap();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    mcnt = 32'hFFFF_FFFF;
    drive(1'b1, 5'd2, 1'b0, 1'b0, 32'h9, 32'h0, 32'h0);
    n_chk++;
    if (bus.wb_count !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", bus.wb_count);
    end
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    n_chk++;
    if (bus.wb_count !== 32'd0) begin
      n_fail++; $display("FAIL wrap: got %h want 0", bus.wb_count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom, $urandom, $urandom);
      bus.raddr1 = 5'($urandom_range(0, 31));
      bus.raddr2 = ($urandom_range(0, 3) == 0) ? bus.waddr_in : 5'($urandom_range(0, 31));
      #1;
      n_chk++;
      if (bus.wb_wen !== exp_wen() || bus.wb_waddr !== bus.waddr_in || bus.wb_data !== sel_val()) begin
        n_fail++;
        $display("FAIL rnd_wb c=%0d: got %b/%h/%h want %b/%h/%h", c, bus.wb_wen,
                 bus.wb_waddr, bus.wb_data, exp_wen(), bus.waddr_in, sel_val());
      end
      n_chk++;
      if (bus.rdata1 !== exp_rd(bus.raddr1) || bus.rdata2 !== exp_rd(bus.raddr2)) begin
        n_fail++;
        $display("FAIL rnd_read c=%0d: got %h/%h want %h/%h", c, bus.rdata1, bus.rdata2,
                 exp_rd(bus.raddr1), exp_rd(bus.raddr2));
      end
      n_chk++;
      if (bus.wb_count !== mcnt) begin
        n_fail++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, bus.wb_count, mcnt);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcnt = 32'd0;
    bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
    test_reset();
    test_alu_write();
    test_select();
    test_r0();
    test_bypass();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
